uart_apb_fifo_regs: RTL and testbench

- Parametrised APB register front-end for the UART, the successor to the single-byte register block.
- Adds separate TX and RX FIFOs and a programmable baud divisor.
- Adds maskable interrupts with sticky error flags, and a valid/ready handshake to the TX and RX bit engines.
- Sits between the APB bus and the UART TX/RX serialisers and the baud clock generator.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_apb_fifo_regs.sv | 179 +++++++++++++++++
 tb/tb_uart_apb_fifo_regs.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, interrupt bit indices and STATUS field positions for the UART APB front-end.
package uart_pkg;

    localparam logic [7:0] ADDR_DATA     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h10;
    localparam logic [7:0] ADDR_BAUD     = 8'h14;

    localparam int unsigned IRQ_W        = 5;
    localparam int unsigned IRQ_RX_THR   = 0;
    localparam int unsigned IRQ_TX_EMPTY = 1;
    localparam int unsigned IRQ_RX_OVR   = 2;
    localparam int unsigned IRQ_FRAME    = 3;
    localparam int unsigned IRQ_TX_OVF   = 4;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_TX_LVL   = 8;
    localparam int unsigned ST_RX_LVL   = 16;

    localparam int unsigned DATA_FE_BIT = 9;

    typedef struct packed {
        logic [7:0] rx_thresh;
        logic       rx_en;
        logic       tx_en;
    } ctrl_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted only alongside a real pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: dout is gated while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_apb_fifo_regs.sv
// APB register front-end for the UART: TX/RX FIFOs, baud divisor, maskable interrupts with sticky errors.
module uart_apb_fifo_regs
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned RX_DEPTH     = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd325
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSel,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [31:0]       pAddr,
    input  logic [31:0]       pWdata,
    output logic [31:0]       pReadData,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_err,
    output logic [15:0]       baud_div,
    output logic              irq
);
    localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_LW = $clog2(RX_DEPTH) + 1;
    localparam int unsigned RX_W  = DATA_W + 1;

    ctrl_t            ctrl_q, ctrl_d;
    logic [IRQ_W-1:0] irq_en_q, irq_en_d;
    logic [15:0]      baud_q, baud_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             frame_q, frame_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             irq_q, irq_d;

    logic [7:0]       addr;
    logic             wr_en, rd_en;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [TX_LW-1:0] tx_level;
    logic [RX_LW-1:0] rx_level;
    logic [RX_W-1:0]  rx_dout;
    logic             tx_ovf_set, rx_ovr_set, frame_set, rx_thr;
    logic [IRQ_W-1:0] irq_stat;
    logic             unused_ok;

    assign addr      = pAddr[7:0];
    assign wr_en     = pSel && pEnable && pWrite;
    assign rd_en     = pSel && pEnable && !pWrite;
    assign unused_ok = ^{pAddr, pWdata};

    assign tx_valid   = ctrl_q.tx_en && !tx_empty;
    assign tx_push    = wr_en && (addr == ADDR_DATA);
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;

    assign rx_push    = rx_valid && ctrl_q.rx_en;
    assign rx_pop     = rd_en && (addr == ADDR_DATA) && !rx_empty;
    assign rx_ovr_set = rx_push && rx_full && !rx_pop;
    assign frame_set  = rx_push && rx_frame_err;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (pClk),
        .rst   (pReset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (pWdata[DATA_W-1:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_sync_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (pClk),
        .rst   (pReset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   ({rx_frame_err, rx_data}),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign rx_thr = (ctrl_q.rx_thresh != 8'd0) && (8'(rx_level) >= ctrl_q.rx_thresh);

    always_comb begin
        irq_stat               = '0;
        irq_stat[IRQ_RX_THR]   = rx_thr;
        irq_stat[IRQ_TX_EMPTY] = tx_empty;
        irq_stat[IRQ_RX_OVR]   = rx_ovr_q;
        irq_stat[IRQ_FRAME]    = frame_q;
        irq_stat[IRQ_TX_OVF]   = tx_ovf_q;
    end

    // Register writes, then sticky sets so a same-cycle set beats W1C.
    always_comb begin
        ctrl_d   = ctrl_q;
        irq_en_d = irq_en_q;
        baud_d   = baud_q;
        rx_ovr_d = rx_ovr_q;
        frame_d  = frame_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_en) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d.tx_en     = pWdata[0];
                    ctrl_d.rx_en     = pWdata[1];
                    ctrl_d.rx_thresh = pWdata[15:8];
                end
                ADDR_IRQ_EN: irq_en_d = pWdata[IRQ_W-1:0];
                ADDR_IRQ_STAT: begin
                    if (pWdata[IRQ_RX_OVR]) rx_ovr_d = 1'b0;
                    if (pWdata[IRQ_FRAME])  frame_d  = 1'b0;
                    if (pWdata[IRQ_TX_OVF]) tx_ovf_d = 1'b0;
                end
                ADDR_BAUD: baud_d = pWdata[15:0];
                default: ;
            endcase
        end
        if (rx_ovr_set) rx_ovr_d = 1'b1;
        if (frame_set)  frame_d  = 1'b1;
        if (tx_ovf_set) tx_ovf_d = 1'b1;
        irq_d = |(irq_stat & irq_en_q);
    end

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            ctrl_q   <= '0;
            irq_en_q <= '0;
            baud_q   <= BAUD_DIV_RST;
            rx_ovr_q <= 1'b0;
            frame_q  <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            irq_en_q <= irq_en_d;
            baud_q   <= baud_d;
            rx_ovr_q <= rx_ovr_d;
            frame_q  <= frame_d;
            tx_ovf_q <= tx_ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign baud_div = baud_q;
    assign irq      = irq_q;

    always_comb begin
        pReadData = '0;
        if (pSel && !pWrite) begin
            case (addr)
                ADDR_DATA: begin
                    pReadData              = 32'(rx_dout[DATA_W-1:0]);
                    pReadData[DATA_FE_BIT] = rx_dout[DATA_W];
                end
                ADDR_STATUS: begin
                    pReadData[ST_TX_FULL]      = tx_full;
                    pReadData[ST_TX_EMPTY]     = tx_empty;
                    pReadData[ST_RX_FULL]      = rx_full;
                    pReadData[ST_RX_EMPTY]     = rx_empty;
                    pReadData[ST_TX_LVL +: 8]  = 8'(tx_level);
                    pReadData[ST_RX_LVL +: 8]  = 8'(rx_level);
                end
                ADDR_CTRL:     pReadData = {16'h0, ctrl_q.rx_thresh, 6'h0, ctrl_q.rx_en, ctrl_q.tx_en};
                ADDR_IRQ_EN:   pReadData = 32'(irq_en_q);
                ADDR_IRQ_STAT: pReadData = 32'(irq_stat);
                ADDR_BAUD:     pReadData = 32'(baud_q);
                default:       pReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_fifo_regs.sv
// Directed bench for uart_apb_fifo_regs: register map, TX/RX FIFO paths, interrupts and reset.
module tb_uart_apb_fifo_regs;

    logic        pClk = 1'b0;
    logic        pReset;
    logic        pSel, pEnable, pWrite;
    logic [31:0] pAddr, pWdata, pReadData;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_frame_err;
    logic [15:0] baud_div;
    logic        irq;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] rd;

    uart_apb_fifo_regs dut (
        .pClk         (pClk),
        .pReset       (pReset),
        .pSel         (pSel),
        .pEnable      (pEnable),
        .pWrite       (pWrite),
        .pAddr        (pAddr),
        .pWdata       (pWdata),
        .pReadData    (pReadData),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .baud_div     (baud_div),
        .irq          (irq)
    );

    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each transfer starts and ends on a falling edge: setup cycle, then access cycle.
    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        pSel = 1'b1; pWrite = 1'b1; pAddr = 32'(a); pWdata = d; pEnable = 1'b0;
        @(negedge pClk);
        pEnable = 1'b1;
        @(negedge pClk);
        pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        pSel = 1'b1; pWrite = 1'b0; pAddr = 32'(a); pEnable = 1'b0;
        @(negedge pClk);
        pEnable = 1'b1;
        #1 d = pReadData;
        @(negedge pClk);
        pSel = 1'b0; pEnable = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] d, input logic fe);
        rx_data = d; rx_frame_err = fe; rx_valid = 1'b1;
        @(negedge pClk);
        rx_valid = 1'b0; rx_frame_err = 1'b0;
    endtask

    initial begin
        pReset = 1'b1; pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        pAddr = '0; pWdata = '0; tx_ready = 1'b0;
        rx_data = '0; rx_valid = 1'b0; rx_frame_err = 1'b0;
        repeat (2) @(negedge pClk);
        pReset = 1'b0;

        // Reset state
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_baud_div", 32'(baud_div), 32'h145);
        #1 chk("idle_rdata", pReadData, 32'h0);
        apb_rd(8'h08, rd); chk("rst_ctrl", rd, 32'h0);
        apb_rd(8'h0C, rd); chk("rst_irq_en", rd, 32'h0);
        apb_rd(8'h14, rd); chk("rst_baud", rd, 32'h145);
        apb_rd(8'h04, rd); chk("rst_status", rd, 32'h0000_000A);
        apb_rd(8'h10, rd); chk("rst_irq_stat", rd, 32'h02);
        apb_rd(8'h1C, rd); chk("unmapped_rd", rd, 32'h0);

        // TX in-order delivery
        apb_wr(8'h08, 32'h1);
        apb_wr(8'h00, 32'h41);
        apb_wr(8'h00, 32'h42);
        apb_wr(8'h00, 32'h43);
        chk("tx_valid_3", 32'(tx_valid), 32'h1);
        chk("tx_head_3", 32'(tx_data), 32'h41);
        apb_rd(8'h04, rd); chk("status_tx3", rd, 32'h0000_0308);
        for (int i = 0; i < 3; i++) begin
            chk("tx_seq_valid", 32'(tx_valid), 32'h1);
            chk("tx_seq_data", 32'(tx_data), 32'(8'h41 + i));
            tx_ready = 1'b1;
            @(negedge pClk);
            tx_ready = 1'b0;
        end
        chk("tx_drained_valid", 32'(tx_valid), 32'h0);
        chk("tx_drained_data", 32'(tx_data), 32'h0);

        // TX overflow with tx_en=0, contents retained
        apb_wr(8'h08, 32'h0);
        for (int i = 0; i < 17; i++) apb_wr(8'h00, 32'h60 + 32'(i));
        chk("tx_full_valid_off", 32'(tx_valid), 32'h0);
        apb_rd(8'h04, rd); chk("status_tx_full", rd, 32'h0000_1009);
        apb_rd(8'h10, rd); chk("irq_stat_txovf", rd, 32'h10);
        apb_wr(8'h10, 32'h10);
        apb_rd(8'h10, rd); chk("irq_stat_w1c", rd, 32'h00);
        apb_wr(8'h08, 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_full_seq", 32'(tx_data), 32'(8'h60 + i));
            @(negedge pClk);
        end
        tx_ready = 1'b0;
        chk("tx_17th_dropped", 32'(tx_valid), 32'h0);

        // RX threshold interrupt with one-cycle latency
        apb_wr(8'h08, 32'h202);
        apb_rd(8'h08, rd); chk("ctrl_rb", rd, 32'h202);
        apb_wr(8'h0C, 32'h01);
        rx_data = 8'h55; rx_valid = 1'b1;
        @(negedge pClk);
        rx_data = 8'hAA;
        @(negedge pClk);
        rx_valid = 1'b0;
        chk("irq_latency_lo", 32'(irq), 32'h0);
        @(negedge pClk);
        chk("irq_thr_hi", 32'(irq), 32'h1);
        apb_rd(8'h00, rd); chk("rx_rd_55", rd, 32'h055);
        apb_rd(8'h00, rd); chk("rx_rd_aa", rd, 32'h0AA);
        chk("irq_thr_lo", 32'(irq), 32'h0);

        // RX overrun, then simultaneous read and strobe at full
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i + 1);
            @(negedge pClk);
        end
        rx_data = 8'h99;
        @(negedge pClk);
        rx_valid = 1'b0;
        apb_rd(8'h04, rd); chk("status_rx_full", rd, 32'h0010_0006);
        apb_rd(8'h10, rd); chk("irq_stat_ovr", rd, 32'h07);
        apb_wr(8'h10, 32'h04);
        apb_rd(8'h10, rd); chk("ovr_w1c", rd, 32'h03);
        pSel = 1'b1; pWrite = 1'b0; pAddr = 32'h0; pEnable = 1'b0;
        @(negedge pClk);
        pEnable = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        #1 rd = pReadData;
        @(negedge pClk);
        pSel = 1'b0; pEnable = 1'b0; rx_valid = 1'b0;
        chk("rx_simul_rd", rd, 32'h001);
        apb_rd(8'h10, rd); chk("rx_simul_no_ovr", rd, 32'h03);
        apb_rd(8'h04, rd); chk("rx_simul_level", rd, 32'h0010_0006);
        for (int i = 0; i < 16; i++) begin
            apb_rd(8'h00, rd);
            chk("rx_drain", rd, (i < 15) ? 32'(i + 2) : 32'h077);
        end
        apb_rd(8'h00, rd); chk("rx_empty_rd", rd, 32'h0);
        apb_rd(8'h04, rd); chk("status_empty", rd, 32'h0000_000A);
        apb_rd(8'h10, rd); chk("irq_stat_empty", rd, 32'h02);

        // Frame error stored with the character
        rx_strobe(8'h33, 1'b1);
        apb_rd(8'h10, rd); chk("irq_stat_frame", rd, 32'h0A);
        apb_rd(8'h00, rd); chk("rx_frame_rd", rd, 32'h233);

        // rx_en=0 drops the character silently
        apb_wr(8'h08, 32'h200);
        rx_strobe(8'h44, 1'b0);
        apb_rd(8'h04, rd); chk("rx_dropped", rd, 32'h0000_000A);

        // Asynchronous reset mid-handshake
        apb_wr(8'h0C, 32'h08);
        apb_wr(8'h14, 32'h1234);
        apb_wr(8'h08, 32'h1);
        apb_wr(8'h00, 32'h5A);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_baud", 32'(baud_div), 32'h1234);
        chk("pre_rst_tx_data", 32'(tx_data), 32'h5A);
        tx_ready = 1'b1;
        #2 pReset = 1'b1;
        #1;
        chk("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("async_rst_tx_data", 32'(tx_data), 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_baud", 32'(baud_div), 32'h145);
        @(negedge pClk);
        pReset = 1'b0; tx_ready = 1'b0;
        apb_rd(8'h08, rd); chk("post_rst_ctrl", rd, 32'h0);
        apb_rd(8'h10, rd); chk("post_rst_irq_stat", rd, 32'h02);
        apb_rd(8'h04, rd); chk("post_rst_status", rd, 32'h0000_000A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
